// File: rtl/tfr_arbiter.sv
// Round-robin arbiter in front of one toggle-handshake CDC: grants one requester,
// then holds its {id, payload} stable until the crossing's round trip completes.
module tfr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 32,
  parameter int unsigned IDW  = 2,
  parameter int unsigned TMO  = 255
) (
  input  logic                 i_a_clk,
  input  logic                 i_a_reset_n,
  input  logic [NREQ-1:0]      i_req_valid,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic [NREQ*DW-1:0]   i_req_data,
  output logic                 o_tfr_valid,
  input  logic                 i_tfr_ready,
  output logic [IDW+DW-1:0]    o_tfr_data,
  output logic                 o_busy,
  output logic                 o_timeout
);

  localparam int unsigned   TW    = 16;
  localparam logic [TW-1:0] TMO_V = TW'(TMO);
  localparam logic [TW-1:0] T_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    FLIGHT = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IDW-1:0]  rr_ptr;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   timer_inc;
  logic [IDW-1:0]  hi_id;
  logic [IDW-1:0]  lo_id;
  logic            hi_any;
  logic            lo_any;
  logic [IDW-1:0]  grant_id;
  logic [NREQ-1:0] grant_vec;
  logic [DW-1:0]   grant_data;
  logic            grant_fire;
  logic            accept;
  logic            flight_done;

  // Lowest valid index at/after rr_ptr, falling back to the lowest valid overall (wrap).
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_id  = '0;
    lo_id  = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (i_req_valid[k]) begin
        lo_any = 1'b1;
        lo_id  = IDW'(k);
        if (k >= int'(rr_ptr)) begin
          hi_any = 1'b1;
          hi_id  = IDW'(k);
        end
      end
    end
  end

  always_comb begin
    grant_id   = hi_any ? hi_id : lo_id;
    grant_vec  = '0;
    grant_data = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      grant_vec[k] = lo_any && (grant_id == IDW'(k));
      if (grant_vec[k]) grant_data = i_req_data[k*DW +: DW];
    end
  end

  assign grant_fire  = (state == IDLE) && i_tfr_ready && lo_any;
  assign accept      = (state == SEND) && i_tfr_ready;
  // First FLIGHT cycle (timer still 0) may see a stale ready from the accept.
  assign flight_done = (state == FLIGHT) && i_tfr_ready && (timer != '0);
  assign timer_inc   = (timer == T_MAX) ? timer : timer + 1'b1;

  always_ff @(posedge i_a_clk or negedge i_a_reset_n) begin
    if (!i_a_reset_n) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_fire)  state_nxt = SEND;
      SEND:    if (accept)      state_nxt = FLIGHT;
      FLIGHT:  if (flight_done) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = '0;
    o_busy      = (state != IDLE);
    if (grant_fire) o_req_ready = grant_vec;
  end

  // Holding register, round-robin pointer and round-trip watchdog.
  always_ff @(posedge i_a_clk or negedge i_a_reset_n) begin
    if (!i_a_reset_n) begin
      rr_ptr      <= '0;
      o_tfr_valid <= 1'b0;
      o_tfr_data  <= '0;
      o_timeout   <= 1'b0;
      timer       <= '0;
    end else if (grant_fire) begin
      o_tfr_data  <= {grant_id, grant_data};
      rr_ptr      <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
      o_tfr_valid <= 1'b1;
    end else if (accept) begin
      o_tfr_valid <= 1'b0;
      timer       <= '0;
    end else if (state == FLIGHT) begin
      timer <= timer_inc;
      if (timer_inc >= TMO_V) o_timeout <= 1'b1;
    end
  end

endmodule
